// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle LEGv8 core.
// Sequences the shared ALU, register file and unified memory port through
// fetch / decode / execute / memory / write-back states. Memory states wait on
// MemReady for at most TIMEOUT+1 cycles. Undefined opcodes and memory timeouts
// are routed through a one-cycle exception state that loads the PC with the
// exception vector and latches the cause in EStatus.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   Op[10:0]            opcode field IR[31:21]
//   Zero                ALU zero flag (used only in BRANCH)
//   MemReady            memory access completes this cycle
//   Reg2Loc, ALUSrc, MemtoReg, RegWrite   datapath selects / enables
//   MemRead, MemWrite   memory strobes
//   IorD                memory address select (0 = PC, 1 = ALU result)
//   IRWrite, PCWrite    instruction register / PC load enables
//   PCSrc[1:0]          00 = PC+4, 01 = branch target, 10 = exception vector
//   ALUOp[1:0]          00 = add, 01 = pass B / CBZ, 10 = R-type funct
//   EPCWrite, Exc       save faulting PC, exception taken this cycle
//   EStatus[3:0]        registered exception cause
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ALUOp,
  output logic        EPCWrite,
  output logic        Exc,
  output logic [3:0]  EStatus
);

  typedef enum logic [3:0] {
    StRst, StFetch, StDecode, StAddr, StMemRd, StWbMem,
    StMemWr, StExec, StWbAlu, StBranch, StExc
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
  localparam logic [3:0] CauseUndef = 4'b0010;
  localparam logic [3:0] CauseMem   = 4'b0100;

  state_e     state_q;
  logic [7:0] wait_q;
  logic [3:0] estatus_q;

  logic is_ldst, is_rtype, is_cbz, timed_out;

  assign is_ldst  = (Op == 11'b11111000010) || (Op == 11'b11111000000);
  assign is_rtype = (Op ==? 11'b1?001011000) || (Op ==? 11'b10?01010000);
  assign is_cbz   = (Op ==? 11'b10110100???);
  // Last permitted wait cycle with no handshake: abort into EXC.
  assign timed_out = !MemReady && (wait_q == TimeoutCnt);

  assign EStatus = estatus_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRst;
      wait_q    <= '0;
      estatus_q <= '0;
    end else begin
      unique case (state_q)
        StRst: begin
          state_q <= StFetch;
          wait_q  <= '0;
        end
        StFetch: begin
          if (MemReady) begin
            state_q <= StDecode;
          end else if (timed_out) begin
            state_q   <= StExc;
            estatus_q <= CauseMem;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StDecode: begin
          if (is_ldst) begin
            state_q <= StAddr;
          end else if (is_rtype) begin
            state_q <= StExec;
          end else if (is_cbz) begin
            state_q <= StBranch;
          end else begin
            state_q   <= StExc;
            estatus_q <= CauseUndef;
          end
        end
        StAddr: begin
          // Op[1] separates LDUR (..010) from STUR (..000); IR is stable here.
          state_q <= Op[1] ? StMemRd : StMemWr;
          wait_q  <= '0;
        end
        StMemRd, StMemWr: begin
          if (MemReady) begin
            state_q <= (state_q == StMemRd) ? StWbMem : StFetch;
            wait_q  <= '0;
          end else if (timed_out) begin
            state_q   <= StExc;
            estatus_q <= CauseMem;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StExec: state_q <= StWbAlu;
        StWbMem, StWbAlu, StBranch, StExc: begin
          state_q <= StFetch;
          wait_q  <= '0;
        end
        default: state_q <= StRst;
      endcase
    end
  end

  always_comb begin
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 2'b00;
    ALUOp    = 2'b00;
    EPCWrite = 1'b0;
    Exc      = 1'b0;
    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      StAddr: ALUSrc = 1'b1;
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        ALUSrc  = 1'b1;
      end
      StWbMem: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        ALUSrc   = 1'b1;
        Reg2Loc  = 1'b1;
      end
      StExec: ALUOp = 2'b10;
      StWbAlu: begin
        RegWrite = 1'b1;
        ALUOp    = 2'b10;
      end
      StBranch: begin
        Reg2Loc = 1'b1;
        ALUOp   = 2'b01;
        PCWrite = Zero;
        PCSrc   = Zero ? 2'b01 : 2'b00;
      end
      StExc: begin
        Exc      = 1'b1;
        EPCWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSrc    = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. The driver reacts to the memory strobes
// like a memory with a planned number of wait cycles per access, and for every
// instruction pushes the expected per-instruction summary (cycle count, write
// and strobe counts, PC write sources, resulting EStatus) computed from the
// instruction-level timing rules. The monitor splits the output stream at each
// fetch entry and compares against the queue.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 15;
  localparam int NumRand = 40;
  localparam int NumDir  = 10;
  localparam int NTotal  = NumDir + NumRand;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [14:0] FetchWaitVec = 15'h0400;

  localparam int CR = 0, CLd = 1, CSt = 2, CCbz = 3, CUndef = 4;

  logic        clk, reset;
  logic [10:0] Op;
  logic        Zero, MemReady;
  logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, IorD;
  logic        IRWrite, PCWrite, EPCWrite, Exc;
  logic [1:0]  PCSrc, ALUOp;
  logic [3:0]  EStatus;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUOp(ALUOp), .EPCWrite(EPCWrite),
    .Exc(Exc), .EStatus(EStatus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         regw;
    int         data;
    int         exc;
    logic [3:0] mask;   // bit k set: some PCWrite cycle used PCSrc == k
    logic [3:0] est;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [3:0] model_est = 4'd0;
  bit   mon_en = 1'b1;

  logic [10:0] d_op [NumDir] = '{11'b10001011000, OpLdur, 11'b10110100101, 11'b10110100101,
                                 11'b00000000000, 11'b10001011000, OpStur, OpStur, OpLdur,
                                 11'b11001011000};
  bit d_z [NumDir] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  int d_fw [NumDir] = '{0, 0, 0, 0, 0, 0, 0, 0, 16, 15};
  int d_dw [NumDir] = '{0, 2, 0, 0, 0, 0, 16, 15, 0, 0};

  function automatic logic [14:0] outs();
    return {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, IorD, IRWrite,
            PCWrite, PCSrc, ALUOp, EPCWrite, Exc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int op_class(input logic [10:0] op);
    if (op == OpLdur) return CLd;
    if (op == OpStur) return CSt;
    if ((op ==? 11'b1?001011000) || (op ==? 11'b10?01010000)) return CR;
    if (op ==? 11'b10110100???) return CCbz;
    return CUndef;
  endfunction

  // Instruction-level reference: cycles = fetch (waits+1) + decode + class tail.
  task automatic predict(input logic [10:0] op, input bit z, input int fw, input int dw);
    exp_t e;
    int   cl;
    cl = op_class(op);
    e.regw = 0; e.data = 0; e.exc = 0; e.mask = 4'b0000;
    if (fw > TIMEOUT) begin
      e.cyc = TIMEOUT + 2; e.exc = 1; e.mask = 4'b0100; model_est = 4'd4;
    end else begin
      e.cyc = fw + 2; e.mask = 4'b0001;
      case (cl)
        CR: begin e.cyc += 2; e.regw = 1; end
        CCbz: begin e.cyc += 1; if (z) e.mask |= 4'b0010; end
        CUndef: begin e.cyc += 1; e.exc = 1; e.mask |= 4'b0100; model_est = 4'd2; end
        default: begin
          e.cyc += 1;
          if (dw > TIMEOUT) begin
            e.data = TIMEOUT + 1; e.cyc += TIMEOUT + 2; e.exc = 1;
            e.mask |= 4'b0100; model_est = 4'd4;
          end else begin
            e.data = dw + 1; e.cyc += dw + 1;
            if (cl == CLd) begin e.cyc += 1; e.regw = 1; end
          end
        end
      endcase
    end
    e.est = model_est;
    exp_q.push_back(e);
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return 0;
    if (r < 85) return $urandom_range(1, 4);
    if (r < 92) return 15;
    if (r < 97) return 16;
    return 20;
  endfunction

  function automatic logic [10:0] rand_op();
    logic [10:0] rtab [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                              11'b10101010000};
    logic [10:0] op;
    int k;
    k = $urandom_range(0, 9);
    if (k == 2) return OpLdur;
    if (k == 3) return OpStur;
    if (k == 4 || k == 5) return {8'b10110100, 3'($urandom)};
    if (k == 6) begin
      op = 11'($urandom);
      while (op_class(op) != CUndef) op = 11'($urandom);
      return op;
    end
    return rtab[$urandom_range(0, 3)];
  endfunction

  // Monitor: one transaction spans from a fetch entry to the next fetch entry.
  initial begin
    bit   open, prev_f, is_f;
    int   a_cyc, a_regw, a_data, a_exc;
    logic [3:0] a_mask;
    exp_t e;
    open = 0; prev_f = 0;
    a_cyc = 0; a_regw = 0; a_data = 0; a_exc = 0; a_mask = 0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && reset) begin
        is_f = MemRead && !IorD;
        if (is_f && !prev_f) begin
          if (open) begin
            if (exp_q.size() == 0) begin
              check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
              e = exp_q.pop_front();
              check("cycles", 32'(a_cyc), 32'(e.cyc));
              check("regwrite_cnt", 32'(a_regw), 32'(e.regw));
              check("strobe_cnt", 32'(a_data), 32'(e.data));
              check("exc_cnt", 32'(a_exc), 32'(e.exc));
              check("pcsrc_mask", 32'(a_mask), 32'(e.mask));
              check("estatus", 32'(EStatus), 32'(e.est));
            end
          end
          open = 1;
          a_cyc = 0; a_regw = 0; a_data = 0; a_exc = 0; a_mask = 0;
        end
        a_cyc++;
        a_regw += int'(RegWrite);
        a_data += int'((MemRead && IorD) || MemWrite);
        a_exc  += int'(Exc);
        if (PCWrite) a_mask[PCSrc] = 1'b1;
        prev_f = is_f;
      end
    end
  end

  // Driver: memory responder plus instruction issue.
  initial begin
    logic [10:0] cur_op;
    bit  cur_z, f, d, pf, pd, seen;
    int  cur_fw, cur_dw, fcnt, dcnt, n_issued, cyc;
    cur_op = '0; cur_z = 0; cur_fw = 0; cur_dw = 0;
    fcnt = 0; dcnt = 0; n_issued = 0; cyc = 0; pf = 0; pd = 0;

    reset = 1'b0; Op = '0; Zero = 1'b0; MemReady = 1'b0;
    #12;
    check("reset_outputs", 32'(outs()), 32'd0);
    check("reset_estatus", 32'(EStatus), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        n_checks++;
        $display("FAIL cycle_budget: issued %0d, expected %0d", n_issued, NTotal);
        break;
      end
      f = MemRead && !IorD;
      d = (MemRead && IorD) || MemWrite;
      if (f && !pf) begin
        if (n_issued == NTotal) break;
        if (n_issued < NumDir) begin
          cur_op = d_op[n_issued]; cur_z = d_z[n_issued];
          cur_fw = d_fw[n_issued]; cur_dw = d_dw[n_issued];
        end else begin
          cur_op = rand_op(); cur_z = 1'($urandom);
          cur_fw = rand_wait(); cur_dw = rand_wait();
        end
        predict(cur_op, cur_z, cur_fw, cur_dw);
        n_issued++;
        fcnt = 0;
      end
      if (d && !pd) dcnt = 0;
      pf = f; pd = d;
      if (f) begin
        if (fcnt >= cur_fw) begin MemReady = 1'b1; Op = cur_op; end
        else begin MemReady = 1'b0; fcnt++; end
      end else if (d) begin
        if (dcnt >= cur_dw) MemReady = 1'b1;
        else begin MemReady = 1'b0; dcnt++; end
      end else begin
        MemReady = 1'($urandom);
      end
      // Zero only matters in BRANCH (Reg2Loc without MemWrite).
      Zero = (Reg2Loc && !MemWrite) ? cur_z : 1'($urandom);
    end

    // Asynchronous reset in the middle of a STUR memory wait.
    MemReady = 1'b1; Op = OpStur;
    @(negedge clk);
    mon_en = 1'b0;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    MemReady = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (MemWrite) begin seen = 1; break; end
    end
    check("reach_memwr", 32'(seen), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", 32'(outs()), 32'd0);
    check("async_reset_estatus", 32'(EStatus), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    MemReady = 1'b0;
    @(posedge clk);
    #1;
    check("fetch_after_release", 32'(outs()), 32'(FetchWaitVec));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
